// File: rtl/pe_noc_bridge.sv
// pe_noc_bridge
//   Network interface between one processing element (PE) and its NoC switch
//   port. Two independent first-word-fall-through FIFOs: TX carries PE flits to
//   the switch, RX carries switch flits to the PE. RX exerts backpressure on the
//   switch through o_ready. Saturating flit counters and FIFO fill levels are
//   exported for the scheduler and for debug.
//
//   Build option: define PE_BRIDGE_ADDR_CHECK_EN to enable the destination
//   filter. When it is enabled, a switch flit whose destination field does not
//   equal (X,Y) is discarded and counted in o_drop_cnt. When it is not defined,
//   every accepted switch flit enters the RX FIFO and o_drop_cnt is 0.
//
// Ports
//   clk, rstn               clock (rising edge), asynchronous active-low reset
//   i_data/i_valid/o_ready  switch -> bridge flit channel (into the RX FIFO)
//   o_data/o_valid/i_ready  bridge -> switch flit channel (TX FIFO head)
//   i_pe_data/i_pe_valid/o_pe_ready  PE -> bridge flit channel (into the TX FIFO)
//   o_pe_data/o_pe_valid/i_pe_ready  bridge -> PE flit channel (RX FIFO head)
//   i_cnt_clr               synchronous clear of all counters
//   o_tx_cnt/o_rx_cnt/o_drop_cnt     saturating flit counters
//   o_tx_level/o_rx_level   registered FIFO occupancy
//
// Handshake: a flit moves on a rising clk edge where valid && ready are both
// high. A source never derives valid from ready. Readies are held low from reset
// until the first clock edge after reset release (rst_done).
module pe_noc_bridge #(
  parameter int X           = 0,
  parameter int Y           = 0,
  parameter int total_width = 280,
  parameter int x_size      = 4,
  parameter int y_size      = 4,
  parameter int TX_DEPTH    = 16,
  parameter int RX_DEPTH    = 16,
  parameter int CNT_W       = 32
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [total_width-1:0]       i_data,
  input  logic                         i_valid,
  output logic                         o_ready,
  output logic [total_width-1:0]       o_data,
  output logic                         o_valid,
  input  logic                         i_ready,
  input  logic [total_width-1:0]       i_pe_data,
  input  logic                         i_pe_valid,
  output logic                         o_pe_ready,
  output logic [total_width-1:0]       o_pe_data,
  output logic                         o_pe_valid,
  input  logic                         i_pe_ready,
  input  logic                         i_cnt_clr,
  output logic [CNT_W-1:0]             o_tx_cnt,
  output logic [CNT_W-1:0]             o_rx_cnt,
  output logic [CNT_W-1:0]             o_drop_cnt,
  output logic [$clog2(TX_DEPTH):0]    o_tx_level,
  output logic [$clog2(RX_DEPTH):0]    o_rx_level
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam logic [TX_AW:0]   TX_ONE  = (TX_AW+1)'(1);
  localparam logic [RX_AW:0]   RX_ONE  = (RX_AW+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Saturating increment: an all-ones counter holds its value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_ONE;
  endfunction

  logic rst_done;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rst_done <= 1'b0;
    else       rst_done <= 1'b1;
  end

  // ---------------- TX FIFO (PE -> switch) ----------------
  // Pointers carry one extra wrap bit: equal addresses with equal wrap bits is
  // empty, equal addresses with different wrap bits is full.
  logic [total_width-1:0] tx_mem [TX_DEPTH];
  logic [TX_AW:0]         tx_wr_ptr, tx_rd_ptr, tx_level;
  logic                   tx_empty, tx_full, tx_push, tx_pop;

  assign tx_empty   = (tx_wr_ptr == tx_rd_ptr);
  assign tx_full    = (tx_wr_ptr[TX_AW-1:0] == tx_rd_ptr[TX_AW-1:0]) &&
                      (tx_wr_ptr[TX_AW] != tx_rd_ptr[TX_AW]);
  // Full blocks the push even when a pop happens on the same edge.
  assign o_pe_ready = rst_done && !tx_full;
  assign o_valid    = !tx_empty;
  assign tx_push    = i_pe_valid && o_pe_ready;
  assign tx_pop     = o_valid && i_ready;
  assign o_data     = tx_mem[tx_rd_ptr[TX_AW-1:0]];
  assign o_tx_level = tx_level;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr[TX_AW-1:0]] <= i_pe_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_level  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_ONE;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_ONE;
      case ({tx_push, tx_pop})
        2'b10:   tx_level <= tx_level + TX_ONE;
        2'b01:   tx_level <= tx_level - TX_ONE;
        default: tx_level <= tx_level;
      endcase
    end
  end

  // ---------------- RX FIFO (switch -> PE) ----------------
  logic [total_width-1:0] rx_mem [RX_DEPTH];
  logic [RX_AW:0]         rx_wr_ptr, rx_rd_ptr, rx_level;
  logic                   rx_empty, rx_full, rx_accept, rx_push, rx_pop;
  logic                   dest_ok, rx_drop;

  assign rx_empty   = (rx_wr_ptr == rx_rd_ptr);
  assign rx_full    = (rx_wr_ptr[RX_AW-1:0] == rx_rd_ptr[RX_AW-1:0]) &&
                      (rx_wr_ptr[RX_AW] != rx_rd_ptr[RX_AW]);
  // Backpressure depends only on FIFO space, so a flit for another node is
  // also held off while the FIFO is full.
  assign o_ready    = rst_done && !rx_full;
  assign o_pe_valid = !rx_empty;
  assign rx_accept  = i_valid && o_ready;
  assign rx_push    = rx_accept && dest_ok;
  assign rx_pop     = o_pe_valid && i_pe_ready;
  assign o_pe_data  = rx_mem[rx_rd_ptr[RX_AW-1:0]];
  assign o_rx_level = rx_level;

`ifdef PE_BRIDGE_ADDR_CHECK_EN
  localparam logic [x_size-1:0] X_COORD = x_size'(X);
  localparam logic [y_size-1:0] Y_COORD = y_size'(Y);
  assign dest_ok = (i_data[x_size-1:0] == X_COORD) &&
                   (i_data[x_size+y_size-1:x_size] == Y_COORD);
  assign rx_drop = rx_accept && !dest_ok;
`else
  logic unused_xy;
  assign unused_xy = (X == Y);
  assign dest_ok   = 1'b1;
  assign rx_drop   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr[RX_AW-1:0]] <= i_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_level  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_ONE;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_ONE;
      case ({rx_push, rx_pop})
        2'b10:   rx_level <= rx_level + RX_ONE;
        2'b01:   rx_level <= rx_level - RX_ONE;
        default: rx_level <= rx_level;
      endcase
    end
  end

  // ---------------- Statistics counters ----------------
  // Clear takes priority over an increment on the same edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_tx_cnt <= '0;
      o_rx_cnt <= '0;
    end else if (i_cnt_clr) begin
      o_tx_cnt <= '0;
      o_rx_cnt <= '0;
    end else begin
      if (tx_pop)  o_tx_cnt <= sat_inc(o_tx_cnt);
      if (rx_push) o_rx_cnt <= sat_inc(o_rx_cnt);
    end
  end

`ifdef PE_BRIDGE_ADDR_CHECK_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)          o_drop_cnt <= '0;
    else if (i_cnt_clr) o_drop_cnt <= '0;
    else if (rx_drop)   o_drop_cnt <= sat_inc(o_drop_cnt);
  end
`else
  logic unused_drop;
  assign unused_drop = rx_drop;
  assign o_drop_cnt  = '0;
`endif

endmodule
